uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- AXI-Stream-to-serial UART transmitter.
- Sits directly downstream of the transmit uart_fifo: consumes its m_axis byte stream and drives the tx line.
- Fixed baud rate via integer clock prescaler; configurable data width, parity and stop bits.
- Frames are LSB-first; idle line is high.

Parameters:
- PRESCALER, 868, aclk cycles per bit period (≥2); 868 gives 115200 baud at 100 MHz.
- DATA_WIDTH, 8, data bits per frame (5..9).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  byte to transmit.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tready  out  1  high only when the block can accept a frame.
- tx  out  1  serial output; idles high.
- busy  out  1  high while a frame is in progress (START..STOP).

Behaviour:
- Reset (async assert, sync release): state = IDLE, tx = 1, busy = 0, s_axis_tready = 0, bit counter = 0, prescale counter = 0. All outputs are registered.
- IDLE: s_axis_tready = 1 from the first clock after reset release.
- Handshake = tvalid & tready in IDLE. On that edge:
  - latch tdata into the shift register;
  - compute parity (XOR of data; inverted for odd);
  - tready -> 0, busy -> 1, state -> START.
- START: tx = 0 for PRESCALER clocks. The start bit begins on the clock edge immediately after the handshake (1-cycle latency).
- DATA: DATA_WIDTH bit periods, LSB first; shift register shifts right at each bit-period end.
- PARITY: one bit period carrying the latched parity bit. Skipped when PARITY = 0.
- STOP: tx = 1 for STOP_BITS × PRESCALER clocks, then state -> IDLE, busy -> 0, tready -> 1.
- Frame length: (1 + DATA_WIDTH + (PARITY≠0) + STOP_BITS) × PRESCALER clocks, from tx falling to IDLE re-entry.
- Back-to-back frames: minimum one aclk of idle-high between consecutive frames, since the handshake is only possible in IDLE. No other gap is inserted.
- Prescale counter: width clog2(PRESCALER). Counts 0..PRESCALER-1 and wraps. Bit-period end = (count == PRESCALER-1). The counter is reset to 0 on handshake so every bit period is exactly PRESCALER clocks.
- Bit counter width: clog2(DATA_WIDTH+1). Counts data bits, and stop bits when STOP_BITS = 2.
- tdata / tvalid changes while not in IDLE are ignored; the latched value is transmitted unchanged.
- tvalid deasserted in IDLE: stay in IDLE, tx = 1 indefinitely.
- areset mid-frame: tx goes high immediately (async) and the frame is truncated. After release the block returns to IDLE/tready = 1 with no residual state; the truncated byte is not retransmitted.
- Illegal parameters (PRESCALER < 2, STOP_BITS not in {1,2}, PARITY > 2): elaboration-time error via generate-time check.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP);
  - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the clogb2 function, shared with uart_fifo and the future uart_rx.
- One natural sub-module: uart_baud_gen.
  - Prescale counter with synchronous restart input.
  - Outputs a single-cycle bit_tick.
  - Reusable by uart_rx at 16× oversampling.

Test Plan (PRESCALER = 4, DATA_WIDTH = 8):
- Reset release, tvalid = 0 -> tx = 1, busy = 0; tready = 0 during reset and 1 one clock after release; tx stays high 100 clocks.
- Send 0xA5, PARITY = 0, STOP_BITS = 1 -> tx falls one clock after handshake. Sampling every 4 clocks gives 0,1,0,1,0,0,1,0,1,1; tready returns at clock 40.
- Send 0x07, PARITY = 1 (even) -> parity bit = 1; send 0x07 with PARITY = 2 (odd) -> parity bit = 0; frame = 44 clocks.
- FIFO streaming 0x11, 0x22, 0x33 with tvalid held high, STOP_BITS = 2 -> three 44-clock frames, each separated by exactly 1 idle clock, bytes received intact by a reference UART model.
- tdata changed to 0xFF mid-frame after sending 0x00 -> transmitted data bits all 0; no extra handshake occurs.
- areset pulsed at clock 15 of a frame -> tx = 1 in the same cycle (async); after release, tready = 1 one clock later, and the next byte 0x3C is framed correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the
// ceiling-log2 helper used by uart_tx, uart_fifo and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bits needed to hold value-1; never less than 1 so counters stay legal.
  function automatic int clogb2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period prescaler: free-running 0..PRESCALER-1 counter with a
// synchronous restart, emitting a one-cycle bit_tick on the last count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int PRESCALER = 868
) (
  input  logic aclk,
  input  logic areset,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = clogb2(PRESCALER);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALER - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (restart || (cnt_q == CNT_MAX)) cnt_d = '0;
    else                               cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bit_tick = (cnt_q == CNT_MAX) && !restart;

endmodule

// File: rtl/uart_tx.sv
// AXI-Stream to serial UART transmitter: one frame per handshake,
// LSB first, optional parity, one or two stop bits, idle-high line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int PRESCALER  = 868,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  tx,
  output logic                  busy
);

  localparam int BIT_W = clogb2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);

  if (PRESCALER < 2) begin : g_bad_prescaler
    $error("uart_tx: PRESCALER must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx: DATA_WIDTH must be in 5..9");
  end

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  tready_q, tready_d;
  logic                  handshake;
  logic                  bit_tick;

  assign handshake = (state_q == ST_IDLE) && tready_q && s_axis_tvalid;

  // Restarting on the handshake aligns every bit period to the start bit.
  uart_baud_gen #(
    .PRESCALER(PRESCALER)
  ) u_baud_gen (
    .aclk    (aclk),
    .areset  (areset),
    .restart (handshake),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    tready_d  = tready_q;
    case (state_q)
      ST_IDLE: begin
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        tready_d = 1'b1;
        if (handshake) begin
          shreg_d   = s_axis_tdata;
          par_d     = (^s_axis_tdata) ^ (PARITY == PAR_ODD);
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          tready_d  = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          tx_d      = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // With two stop bits the counter marks the first stop period as done.
        if (bit_tick) begin
          if (STOP_BITS == 2 && bit_cnt_q == '0) begin
            bit_cnt_d = BIT_W'(1);
          end else begin
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            tready_d  = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        tready_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tready_q  <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign tx            = tx_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at PRESCALER=4, DATA_WIDTH=8 across the
// four parity/stop-bit configurations, one instance per configuration.
module tb_uart_tx;

  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] tdata  [4];
  logic       tvalid [4];
  logic       tready [4];
  logic       tx     [4];
  logic       busy   [4];

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  uart_tx #(.PRESCALER(4), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
    .s_axis_tready(tready[0]), .tx(tx[0]), .busy(busy[0]));
  uart_tx #(.PRESCALER(4), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]),
    .s_axis_tready(tready[1]), .tx(tx[1]), .busy(busy[1]));
  uart_tx #(.PRESCALER(4), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(tdata[2]), .s_axis_tvalid(tvalid[2]),
    .s_axis_tready(tready[2]), .tx(tx[2]), .busy(busy[2]));
  uart_tx #(.PRESCALER(4), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(2)) u3 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(tdata[3]), .s_axis_tvalid(tvalid[3]),
    .s_axis_tready(tready[3]), .tx(tx[3]), .busy(busy[3]));

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One frame on instance idx; samples mid-bit every 4 clocks (bit k of
  // exp_bits is the k-th sampled period, starting with the start bit).
  task automatic send_frame(input int idx, input logic [7:0] d, input logic [15:0] exp_bits,
                            input int exp_len, input logic mid_change, input string name);
    int          cyc;
    int          wait_c;
    int          busy_drop;
    int          idle_bad;
    logic [15:0] bits;
    wait_c = 0;
    while (tready[idx] !== 1'b1 && wait_c < 200) begin
      tick();
      wait_c++;
    end
    checks++;
    if (tready[idx] !== 1'b1) begin
      errors++;
      $display("FAIL %s_tready_wait: tready=%b required 1", name, tready[idx]);
    end
    tdata[idx]  = d;
    tvalid[idx] = 1'b1;
    tick();
    tvalid[idx] = 1'b0;
    checks++;
    if (tx[idx] !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_edge: tx=%b required 0", name, tx[idx]);
    end
    bits      = '0;
    busy_drop = 0;
    cyc       = 0;
    while (tready[idx] !== 1'b1 && cyc < 200) begin
      if (cyc % 4 == 2 && cyc / 4 < 16) bits[cyc/4] = tx[idx];
      if (busy[idx] !== 1'b1) busy_drop++;
      if (mid_change && cyc == 10) begin
        tdata[idx]  = 8'hFF;
        tvalid[idx] = 1'b1;
      end
      if (mid_change && cyc == 34) tvalid[idx] = 1'b0;
      tick();
      cyc++;
    end
    checks++;
    if (bits !== exp_bits) begin
      errors++;
      $display("FAIL %s_bits: got %h required %h", name, bits, exp_bits);
    end
    checks++;
    if (cyc !== exp_len) begin
      errors++;
      $display("FAIL %s_frame_len: got %0d required %0d", name, cyc, exp_len);
    end
    checks++;
    if (busy_drop !== 0) begin
      errors++;
      $display("FAIL %s_busy: busy low in %0d frame cycles, required 0", name, busy_drop);
    end
    idle_bad = 0;
    repeat (6) begin
      tick();
      if (tx[idx] !== 1'b1 || busy[idx] !== 1'b0) idle_bad++;
    end
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("FAIL %s_idle_after: %0d non-idle cycles, required 0", name, idle_bad);
    end
  endtask

  task automatic test_reset();
    int low_cnt;
    areset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tvalid[i] = 1'b0;
      tdata[i]  = 8'h00;
    end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || tready[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: tx=%b busy=%b tready=%b required 1 0 0",
                 i, tx[i], busy[i], tready[i]);
      end
    end
    areset = 1'b0;
    #1;
    checks++;
    if (tready[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_tready_early: tready=%b required 0", tready[0]);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tready[i] !== 1'b1) begin
        errors++;
        $display("FAIL release_tready[%0d]: tready=%b required 1", i, tready[i]);
      end
    end
    low_cnt = 0;
    repeat (100) begin
      tick();
      for (int i = 0; i < 4; i++) if (tx[i] !== 1'b1 || busy[i] !== 1'b0) low_cnt++;
    end
    checks++;
    if (low_cnt !== 0) begin
      errors++;
      $display("FAIL idle_line: %0d non-idle samples, required 0", low_cnt);
    end
  endtask

  task automatic test_basic();
    send_frame(0, 8'hA5, 16'h034A, 40, 1'b0, "a5");
  endtask

  task automatic test_parity();
    send_frame(1, 8'h07, 16'h060E, 44, 1'b0, "even_07");
    send_frame(2, 8'h07, 16'h040E, 44, 1'b0, "odd_07");
  endtask

  task automatic test_mid_change();
    send_frame(0, 8'h00, 16'h0200, 40, 1'b1, "hold_00");
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_b [3] = '{8'h11, 8'h22, 8'h33};
    int          fall  [3] = '{0, 0, 0};
    int          nf;
    int          rc;
    logic        active;
    logic        prev;
    logic        cur;
    logic [10:0] rxb;
    logic [10:0] want;
    nf     = 0;
    rc     = 0;
    active = 1'b0;
    rxb    = '0;
    prev   = tx[3];
    tdata[3]  = exp_b[0];
    tvalid[3] = 1'b1;
    for (int c = 0; c < 400 && !(nf == 3 && !active); c++) begin
      tick();
      cur = tx[3];
      if (!active && prev && !cur) begin
        active   = 1'b1;
        rc       = 0;
        rxb      = '0;
        fall[nf] = c;
        nf++;
        if (nf < 3) tdata[3] = exp_b[nf];
        else        tvalid[3] = 1'b0;
      end
      if (active) begin
        if (rc % 4 == 2) rxb[rc/4] = cur;
        rc++;
        if (rc == 44) begin
          active = 1'b0;
          want   = {2'b11, exp_b[nf-1], 1'b0};
          checks++;
          if (rxb !== want) begin
            errors++;
            $display("FAIL stream_frame%0d: got %h required %h", nf - 1, rxb, want);
          end
        end
      end
      prev = cur;
    end
    tvalid[3] = 1'b0;
    checks++;
    if (nf !== 3) begin
      errors++;
      $display("FAIL stream_count: got %0d frames required 3", nf);
    end
    checks++;
    if (fall[1] - fall[0] !== 45) begin
      errors++;
      $display("FAIL stream_gap01: got %0d clocks required 45", fall[1] - fall[0]);
    end
    checks++;
    if (fall[2] - fall[1] !== 45) begin
      errors++;
      $display("FAIL stream_gap12: got %0d clocks required 45", fall[2] - fall[1]);
    end
  endtask

  task automatic test_async_reset();
    int wait_c;
    wait_c = 0;
    while (tready[0] !== 1'b1 && wait_c < 200) begin
      tick();
      wait_c++;
    end
    tdata[0]  = 8'h00;
    tvalid[0] = 1'b1;
    tick();
    tvalid[0] = 1'b0;
    repeat (15) tick();
    checks++;
    if (tx[0] !== 1'b0) begin
      errors++;
      $display("FAIL arst_pre: tx=%b required 0", tx[0]);
    end
    #1;
    areset = 1'b1;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || tready[0] !== 1'b0) begin
      errors++;
      $display("FAIL arst_async: tx=%b busy=%b tready=%b required 1 0 0",
               tx[0], busy[0], tready[0]);
    end
    tick();
    areset = 1'b0;
    #1;
    checks++;
    if (tready[0] !== 1'b0) begin
      errors++;
      $display("FAIL arst_release_early: tready=%b required 0", tready[0]);
    end
    tick();
    checks++;
    if (tready[0] !== 1'b1 || tx[0] !== 1'b1) begin
      errors++;
      $display("FAIL arst_release: tready=%b tx=%b required 1 1", tready[0], tx[0]);
    end
    send_frame(0, 8'h3C, 16'h0278, 40, 1'b0, "after_rst_3c");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_mid_change();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
